// File: rtl/navic_prn_correlator.sv
// NavIC L1 PRN correlator: regenerates the primary code from R0/R1/C seeds and
// despreads one signed sample per chip over a full code epoch.
//  state  | meaning
//  IDLE   | waiting for start
//  RUN    | consuming one chip per accepted sample
//  DONE   | one-cycle result pulse; start here chains the next epoch
module navic_prn_correlator #(
    parameter int CODE_LEN = 10230,
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [0:54]                R0_in,
    input  logic [0:54]                R1_in,
    input  logic [0:4]                 C_in,
    input  logic                       s_valid,
    input  logic signed [SAMPLE_W-1:0] s_data,
    output logic                       s_ready,
    output logic                       busy,
    output logic [13:0]                chip_idx,
    output logic                       local_chip,
    output logic                       corr_valid,
    output logic signed [ACC_W-1:0]    corr_out,
    output logic [0:23]                first,
    output logic [0:23]                last
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [0:54]             r0_q, r0_d, r1_q, r1_d;
    logic [0:4]              c_q, c_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, corr_q, corr_d;
    logic [13:0]             idx_q, idx_d;
    logic [0:23]             first_w_q, first_w_d, sr_q, sr_d;
    logic [0:23]             first_q, first_d, last_q, last_d;

    logic                    chip, r0_fb, r1_fb, s_a, s_b, s_c;
    logic signed [ACC_W-1:0] s_ext, acc_nxt;
    logic [0:23]             sr_nxt, first_nxt;

    assign chip  = r1_q[0] ^ c_q[0];
    assign r0_fb = r0_q[50] ^ r0_q[45] ^ r0_q[40] ^ r0_q[20] ^ r0_q[10] ^ r0_q[5] ^ r0_q[0];
    assign s_a   = (r0_q[50] ^ r0_q[45] ^ r0_q[40]) & (r0_q[20] ^ r0_q[10] ^ r0_q[5] ^ r0_q[0]);
    assign s_b   = ((r0_q[50] ^ r0_q[45]) & r0_q[40]) ^ ((r0_q[20] ^ r0_q[10]) & (r0_q[5] ^ r0_q[0]));
    assign s_c   = (r0_q[50] & r0_q[45]) ^ (r0_q[20] & r0_q[10]) ^ (r0_q[5] & r0_q[0]);
    assign r1_fb = s_a ^ s_b ^ s_c ^ r0_q[40] ^ r0_q[35] ^ r0_q[30] ^ r0_q[25] ^ r0_q[15] ^ r0_q[0]
                 ^ r1_q[50] ^ r1_q[45] ^ r1_q[40] ^ r1_q[20] ^ r1_q[10] ^ r1_q[5] ^ r1_q[0];

    // chip 1 maps to -1, so the sample is subtracted
    assign s_ext   = {{(ACC_W-SAMPLE_W){s_data[SAMPLE_W-1]}}, s_data};
    assign acc_nxt = chip ? (acc_q - s_ext) : (acc_q + s_ext);
    assign sr_nxt  = {sr_q[1:23], chip};

    always_comb begin
        first_nxt = first_w_q;
        if (idx_q < 14'd24) begin
            first_nxt[idx_q[4:0]] = chip;
        end
    end

    always_comb begin
        state_d   = state_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        c_d       = c_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        first_w_d = first_w_q;
        sr_d      = sr_q;
        corr_d    = corr_q;
        first_d   = first_q;
        last_d    = last_q;
        if (start) begin
            state_d = S_RUN;
            r0_d    = R0_in;
            r1_d    = R1_in;
            c_d     = C_in;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (s_valid) begin
                        r0_d      = {r0_q[1:54], r0_fb};
                        r1_d      = {r1_q[1:54], r1_fb};
                        c_d       = {c_q[1:4], c_q[0]};
                        acc_d     = acc_nxt;
                        idx_d     = idx_q + 14'd1;
                        first_w_d = first_nxt;
                        sr_d      = sr_nxt;
                        if (idx_q == 14'(CODE_LEN - 1)) begin
                            state_d = S_DONE;
                            corr_d  = acc_nxt;
                            first_d = first_nxt;
                            last_d  = sr_nxt;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            r0_q      <= '0;
            r1_q      <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            first_w_q <= '0;
            sr_q      <= '0;
            corr_q    <= '0;
            first_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            c_q       <= c_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            first_w_q <= first_w_d;
            sr_q      <= sr_d;
            corr_q    <= corr_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    assign s_ready    = (state_q == S_RUN) && !start;
    assign busy       = (state_q == S_RUN);
    assign corr_valid = (state_q == S_DONE);
    assign chip_idx   = idx_q;
    assign local_chip = chip;
    assign corr_out   = corr_q;
    assign first      = first_q;
    assign last       = last_q;

endmodule

// File: doc/navic_prn_correlator.md
# navic_prn_correlator

Receive-side counterpart of the NavIC L1 PRN code generator. It regenerates the same primary code chip by chip from the same R0/R1/C seeds, despreads an incoming stream of one signed sample per chip against it, and accumulates over one full 10230-chip code epoch. At epoch end it reports the correlation sum, plus the first and last 24 local chips so the result can be cross-checked against the generator.

## Interface
Parameters:
- CODE_LEN, 10230: chips per epoch.
- SAMPLE_W, 8: signed input sample width.
- ACC_W, 22: signed accumulator width. Must be at least ceil(log2(CODE_LEN·2^(SAMPLE_W-1)))+1.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin an epoch with the seeds below.
- R0_in  in  [0:54]  R0 seed; index 0 is MSB.
- R1_in  in  [0:54]  R1 seed.
- C_in  in  [0:4]  C seed.
- s_valid  in  1  sample present.
- s_data  in  SAMPLE_W  signed sample for the current chip.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- busy  out  1  epoch in progress.
- chip_idx  out  14  index of the next chip to be consumed.
- local_chip  out  1  current local chip, R1[0]^C[0].
- corr_valid  out  1  one-cycle pulse; corr_out is new.
- corr_out  out  ACC_W  signed epoch correlation.
- first  out  [0:23]  local chips 0..23; bit 0 is chip 0.
- last  out  [0:23]  local chips 10206..10229; bit 0 is chip 10206.

## Operation
- States:
  - IDLE: reached after reset.
  - RUN.
  - DONE: lasts exactly 1 cycle.
- Transitions:
  - IDLE or DONE, with start → RUN. Load R0/R1/C from the seed inputs; clear acc and chip_idx.
  - DONE, without start → IDLE.
- start in RUN restarts the epoch:
  - Seeds are reloaded and acc and chip_idx are cleared.
  - Any sample handshaken in that cycle is discarded.
- Feedback terms (R0[k] denotes bit k):
  - R0_fb = R0[50]^R0[45]^R0[40]^R0[20]^R0[10]^R0[5]^R0[0].
  - sA = (R0[50]^R0[45]^R0[40]) & (R0[20]^R0[10]^R0[5]^R0[0]).
  - sB = ((R0[50]^R0[45])&R0[40]) ^ ((R0[20]^R0[10])&(R0[5]^R0[0])).
  - sC = (R0[50]&R0[45]) ^ (R0[20]&R0[10]) ^ (R0[5]&R0[0]).
  - R1_fb = sA^sB^sC^R0[40]^R0[35]^R0[30]^R0[25]^R0[15]^R0[0]^R1[50]^R1[45]^R1[40]^R1[20]^R1[10]^R1[5]^R1[0].
- Per accepted sample in RUN:
  - Chip mapping: chip 0 → +1, chip 1 → −1.
  - acc += chip ? −s_data : +s_data, with s_data sign-extended.
  - R0 ← {R0[1:54], R0_fb}.
  - R1 ← {R1[1:54], R1_fb}.
  - C ← {C[1:4], C[0]} (rotate).
  - chip_idx increments.
  - Chips 0..23 are written into first.
  - A 24-bit shift register always shifts the chip in.
- When the sample with chip_idx = CODE_LEN−1 is accepted, go to DONE. In DONE:
  - corr_out = final acc.
  - last = shift register contents.
  - first is held.
- No saturation is performed. ACC_W guarantees no overflow at the defaults.
- Outputs change only in the cases above:
  - corr_out, first and last hold until the next DONE.
  - local_chip and chip_idx reflect the live registers.

## Timing
- Reset values: all outputs 0; state IDLE; R0/R1/C = 0.
- s_ready = 1 exactly when the state is RUN and start = 0.
- busy = 1 in RUN only.
- start sampled at cycle t: RUN and s_ready from t+1; the first handshake consumes chip 0.
- One chip per handshake and at most one per cycle. Stalls (s_valid=0) freeze the LFSRs, acc and chip_idx.
- Last handshake at cycle T: corr_valid=1 and the new corr_out/last visible in cycle T+1; busy=0 in T+1.
- start during DONE (cycle T+1) gives RUN at T+2, so back-to-back epochs are possible.
- rst mid-epoch: immediate return to reset values. No corr_valid is produced for the aborted epoch.

## Test plan
- All-zero seeds, s_data=+127 on every chip with continuous s_valid → corr_out=1,299,210; first=last=0; corr_valid exactly 10231 cycles after start.
- All-zero seeds, s_data=−128 → corr_out=−1,309,440 (no wrap).
- R0=R1=0, C=5'b10000, s_data=+10 → chips repeat 1,0,0,0,0 → first=24'b100001000010000100001000; corr_out=61,380.
- Same as the previous case with s_valid randomly deasserted 50% of cycles → identical corr_out/first/last; chip_idx frozen during stalls.
- start asserted at chip 5000, then rst asserted mid-epoch → restart gives a correct full-epoch result; after rst all outputs 0 and no corr_valid.
- Random seeds with s_data=+1 → first/last match the generator's first/last for the same seeds, and corr_out = 10230 − 2·popcount(code).
